// File: rtl/ddr_wr_burst_if.sv
// Burst-side handshake between the write-data queue and ddr_wr_burst.
// master = write-data queue, slave = ddr_wr_burst.
interface ddr_wr_burst_if #(
  parameter int DQ_WIDTH = 8
);
  logic                  burst_valid;
  logic                  burst_ready;
  logic [8*DQ_WIDTH-1:0] burst_data;
  logic [7:0]            burst_mask;

  modport master (
    output burst_valid,
    output burst_data,
    output burst_mask,
    input  burst_ready
  );

  modport slave (
    input  burst_valid,
    input  burst_data,
    input  burst_mask,
    output burst_ready
  );
endinterface

// File: rtl/ddr_wr_burst.sv
// BL8 write-burst sequencer for one DDR3 byte lane, launching bursts WL sclk cycles after accept.
// Define DDR_WR_DM_EN to store burst_mask and drive it on dm_d; otherwise dm_d is held at zero.
module ddr_wr_burst #(
  parameter int DQ_WIDTH = 8,
  parameter int WL       = 4
) (
  input  logic                  sclk,
  input  logic                  reset,
  ddr_wr_burst_if.slave         bus,
  output logic [4*DQ_WIDTH-1:0] dq_d,
  output logic [3:0]            dm_d,
  output logic                  dq_oe,
  output logic [1:0]            dqs_d,
  output logic                  dqs_oe,
  output logic                  busy
);
  localparam int DEPTH = WL / 2 + 2;
  localparam int PTR_W = $clog2(DEPTH);
  localparam int HALF  = 4 * DQ_WIDTH;

  typedef enum logic [1:0] {
    ROLE_IDLE   = 2'd0,
    ROLE_STROBE = 2'd1,
    ROLE_DATA0  = 2'd2,
    ROLE_DATA1  = 2'd3
  } role_t;

  logic                  ready_r;
  logic                  busy_r;
  logic                  fire_s;
  // bit k set: a burst was accepted k+1 edges ago
  logic [WL+1:0]         launch_r;
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [8*DQ_WIDTH-1:0] data_mem_r [DEPTH];
  logic [8*DQ_WIDTH-1:0] slot_data_s;
  role_t                 role_s;
  logic [HALF-1:0]       dq_d_r;
  logic [3:0]            dm_d_r;
  logic [3:0]            dm_next_s;
  logic                  dq_oe_r;
  logic                  dqs_oe_r;
  logic [1:0]            dqs_d_r;

  assign fire_s          = bus.burst_valid && ready_r && !reset;
  assign bus.burst_ready = ready_r;
  assign slot_data_s     = data_mem_r[rd_ptr_r];

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // Handshake, launch timeline and burst store pointers.
  always_ff @(posedge sclk) begin
    if (reset) begin
      ready_r  <= 1'b0;
      busy_r   <= 1'b0;
      launch_r <= {(WL+2){1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
    end else begin
      ready_r  <= !fire_s;
      busy_r   <= fire_s || (|launch_r);
      launch_r <= {launch_r[WL:0], fire_s};
      if (fire_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      if (role_s == ROLE_DATA1) begin
        rd_ptr_r <= ptr_inc(rd_ptr_r);
      end
    end
  end

  // Burst payload store; entries are consumed in accept order.
  always_ff @(posedge sclk) begin
    if (fire_s) begin
      data_mem_r[wr_ptr_r] <= bus.burst_data;
    end
  end

  // Role of the next output cycle; data outranks pre/postamble.
  always_comb begin
    role_s = ROLE_IDLE;
    if (launch_r[WL-1]) begin
      role_s = ROLE_DATA0;
    end else if (launch_r[WL]) begin
      role_s = ROLE_DATA1;
    end else if (launch_r[WL-2] || launch_r[WL+1]) begin
      role_s = ROLE_STROBE;
    end else begin
      role_s = ROLE_IDLE;
    end
  end

`ifdef DDR_WR_DM_EN
  logic [7:0] mask_mem_r [DEPTH];

  always_ff @(posedge sclk) begin
    if (fire_s) begin
      mask_mem_r[wr_ptr_r] <= bus.burst_mask;
    end
  end

  always_comb begin
    dm_next_s = 4'h0;
    case (role_s)
      ROLE_DATA0: dm_next_s = mask_mem_r[rd_ptr_r][3:0];
      ROLE_DATA1: dm_next_s = mask_mem_r[rd_ptr_r][7:4];
      default:    dm_next_s = 4'h0;
    endcase
  end
`else
  logic unused_mask_s;
  assign unused_mask_s = ^bus.burst_mask;
  assign dm_next_s     = 4'h0;
`endif

  // Registered DQ/DM/DQS drive for the ODDR and tristate primitives.
  always_ff @(posedge sclk) begin
    if (reset) begin
      dq_d_r   <= {HALF{1'b0}};
      dm_d_r   <= 4'h0;
      dq_oe_r  <= 1'b0;
      dqs_oe_r <= 1'b0;
      dqs_d_r  <= 2'b00;
    end else begin
      dm_d_r <= dm_next_s;
      case (role_s)
        ROLE_DATA0: begin
          dq_d_r   <= slot_data_s[HALF-1:0];
          dq_oe_r  <= 1'b1;
          dqs_oe_r <= 1'b1;
          dqs_d_r  <= 2'b01;
        end
        ROLE_DATA1: begin
          dq_d_r   <= slot_data_s[2*HALF-1:HALF];
          dq_oe_r  <= 1'b1;
          dqs_oe_r <= 1'b1;
          dqs_d_r  <= 2'b01;
        end
        ROLE_STROBE: begin
          dq_d_r   <= {HALF{1'b0}};
          dq_oe_r  <= 1'b0;
          dqs_oe_r <= 1'b1;
          dqs_d_r  <= 2'b00;
        end
        default: begin
          dq_d_r   <= {HALF{1'b0}};
          dq_oe_r  <= 1'b0;
          dqs_oe_r <= 1'b0;
          dqs_d_r  <= 2'b00;
        end
      endcase
    end
  end

  assign dq_d   = dq_d_r;
  assign dm_d   = dm_d_r;
  assign dq_oe  = dq_oe_r;
  assign dqs_d  = dqs_d_r;
  assign dqs_oe = dqs_oe_r;
  assign busy   = busy_r;
endmodule
